// File: rtl/sw_pkg.sv
// Shared constants for the slide-switch conditioning block.
package sw_pkg;
  localparam int SW_N                = 3;
  localparam int SW_DEBOUNCE_DEFAULT = 50000;
  localparam int SW_CNT_W            = 16;
  // Short debounce window used only by simulation benches.
  localparam int SW_DEBOUNCE_SIM     = 4;
endpackage

// File: rtl/sw_debounce_ch.sv
// One switch channel: 2-flop synchronizer, stability counter, clean level
// and single-cycle rise/fall pulses.
module sw_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic flip
);
  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             pend;

  assign pend = (s2 != db);
  // Next-edge flip term, exported so the top can register an aligned OR.
  assign flip = pend && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (!pend) begin
        cnt <= '0;
      end else if (flip) begin
        db   <= s2;
        cnt  <= '0;
        rise <= s2;
        fall <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/sw_debounce.sv
// Debounces N_SW raw switches; clean levels feed the LED block, pulses feed
// sequential consumers.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int N_SW            = SW_N,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
  parameter int CNT_W           = SW_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_any_change
);
  logic [N_SW-1:0] flip;

  sw_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch [N_SW-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (sw_raw),
    .db   (sw_db),
    .rise (sw_rise),
    .fall (sw_fall),
    .flip (flip)
  );

  // Registered from the same flip terms so it lines up with rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_any_change <= 1'b0;
    else        sw_any_change <= |flip;
  end
endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench: directed scenarios plus random switch activity against
// a sliding-window reference model.
module tb_sw_debounce;
  import sw_pkg::*;
  localparam int N = SW_N;
  localparam int D = SW_DEBOUNCE_SIM;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_db, sw_rise, sw_fall;
  logic         sw_any_change;

  int total = 0;
  int bad   = 0;

  // Model: newest raw sample at index 0; sample taken k edges ago at index k.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_db, m_rise, m_fall;
  logic         m_any;

  sw_debounce #(.N_SW(N), .DEBOUNCE_CYCLES(D), .CNT_W(SW_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_raw       (sw_raw),
    .sw_db        (sw_db),
    .sw_rise      (sw_rise),
    .sw_fall      (sw_fall),
    .sw_any_change(sw_any_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back('0);
    m_db = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".db"},   32'(sw_db),         32'(m_db));
    chk({tag, ".rise"}, 32'(sw_rise),       32'(m_rise));
    chk({tag, ".fall"}, 32'(sw_fall),       32'(m_fall));
    chk({tag, ".any"},  32'(sw_any_change), 32'(m_any));
  endtask

  // Drive raw, take one edge, advance the model, check 1 ns after the edge.
  // The level seen by the debouncer at an edge is the raw sampled two edges
  // earlier; a channel flips when the last D such levels all differ from db.
  task automatic step(input logic [N-1:0] r, input string tag);
    logic [N-1:0] flip;
    sw_raw = r;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      hist.push_front(r);
      void'(hist.pop_back());
      flip = '1;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < D; j++)
          if (hist[2 + j][i] == m_db[i]) flip[i] = 1'b0;
      m_rise = flip & ~m_db;
      m_fall = flip & m_db;
      m_any  = |flip;
      m_db   = m_db ^ flip;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [N-1:0] r;
    model_clear();

    // 1: reset held with all switches high, then debounce from scratch.
    sw_raw = 3'b111;
    #2;
    check_all("t1_rst_async");
    for (int c = 0; c < 4; c++) step(3'b111, "t1_rst_hold");
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) step(3'b111, "t1_lat");
    chk("t1_db_edge5", 32'(sw_db), 32'h0);
    step(3'b111, "t1_edge6");
    chk("t1_db_edge6",   32'(sw_db),         32'h7);
    chk("t1_rise_edge6", 32'(sw_rise),       32'h7);
    chk("t1_any_edge6",  32'(sw_any_change), 32'h1);
    step(3'b111, "t1_edge7");
    chk("t1_rise_edge7", 32'(sw_rise),       32'h0);
    chk("t1_any_edge7",  32'(sw_any_change), 32'h0);

    // Return to idle.
    for (int c = 0; c < 8; c++) step(3'b000, "idle0");
    chk("idle0_db", 32'(sw_db), 32'h0);

    // 2: clean edge up and back down on channel 0.
    for (int c = 1; c <= 6; c++) step(3'b001, "t2_up");
    chk("t2_db_up",   32'(sw_db),   32'h1);
    chk("t2_rise_up", 32'(sw_rise), 32'h1);
    chk("t2_fall_up", 32'(sw_fall), 32'h0);
    for (int c = 0; c < 3; c++) step(3'b001, "t2_hold");
    for (int c = 1; c <= 6; c++) step(3'b000, "t2_dn");
    chk("t2_fall_dn", 32'(sw_fall), 32'h1);
    chk("t2_db_dn",   32'(sw_db),   32'h0);

    // 3: 3-cycle glitch on channel 1 never propagates.
    for (int c = 0; c < 3; c++) step(3'b010, "t3_glitch");
    for (int c = 0; c < 8; c++) begin
      step(3'b000, "t3_after");
      chk("t3_db1", 32'(sw_db[1]), 32'h0);
    end

    // 4: bounce on channel 2, then held high.
    step(3'b100, "t4_b"); step(3'b000, "t4_b"); step(3'b100, "t4_b");
    step(3'b000, "t4_b");
    for (int c = 1; c <= 5; c++) step(3'b100, "t4_settle");
    chk("t4_db_edge5", 32'(sw_db[2]), 32'h0);
    step(3'b100, "t4_edge6");
    chk("t4_db_edge6",   32'(sw_db[2]),   32'h1);
    chk("t4_rise_edge6", 32'(sw_rise[2]), 32'h1);
    for (int c = 0; c < 4; c++) step(3'b100, "t4_hold");
    for (int c = 0; c < 8; c++) step(3'b000, "idle4");

    // 5: two channels rise in the same cycle.
    for (int c = 1; c <= 6; c++) step(3'b101, "t5");
    chk("t5_db",   32'(sw_db),         32'h5);
    chk("t5_rise", 32'(sw_rise),       32'h5);
    chk("t5_any",  32'(sw_any_change), 32'h1);
    step(3'b101, "t5_next");
    chk("t5_any_next", 32'(sw_any_change), 32'h0);

    // 6: reset mid-count on channel 0 while channel 2 is already high.
    for (int c = 0; c < 3; c++) step(3'b101, "t6_pre");
    for (int c = 0; c < 8; c++) step(3'b100, "t6_ch0low");
    for (int c = 0; c < 3; c++) step(3'b101, "t6_count");
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    chk("t6_db_async", 32'(sw_db), 32'h0);
    check_all("t6_async");
    for (int c = 0; c < 2; c++) step(3'b101, "t6_hold");
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) step(3'b101, "t6_lat");
    chk("t6_db_edge5", 32'(sw_db), 32'h0);
    step(3'b101, "t6_edge6");
    chk("t6_db_edge6",   32'(sw_db),   32'h5);
    chk("t6_rise_edge6", 32'(sw_rise), 32'h5);

    // Random activity: each bit toggles with probability ~1/3 per cycle,
    // with occasional held stretches so the window can complete.
    r = sw_raw;
    for (int c = 0; c < 600; c++) begin
      if ((c / 40) % 2 == 0) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 2) == 0) r[i] = ~r[i];
      end else if ($urandom_range(0, 15) == 0) begin
        r = N'($urandom);
      end
      step(r, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
